// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo and its read-side controller.
package fifo_pkg;

    // Cycles from a pop request to valid read data at the fifo port.
    localparam int FIFO_RD_LATENCY  = 1;
    // Entries in the reader's output buffer.
    localparam int READER_BUF_DEPTH = 2;
    // Default word width for fifo instances and readers.
    localparam int FIFO_DATA_WIDTH  = 32;

    // Output buffer occupancy, 0..READER_BUF_DEPTH.
    typedef logic [1:0] occ_t;

    localparam occ_t BUF_FULL = occ_t'(READER_BUF_DEPTH);

    // Per-cycle buffer operation, encoded as {pop, write}.
    typedef enum logic [1:0] {
        BUF_IDLE   = 2'b00,
        BUF_WR     = 2'b01,
        BUF_POP    = 2'b10,
        BUF_POP_WR = 2'b11
    } buf_op_e;

    function automatic buf_op_e buf_op(input logic pop, input logic wr);
        return buf_op_e'({pop, wr});
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry ordered output buffer: slot 0 is the head, slot 1 queues behind it.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output occ_t                  count
);

    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    occ_t                  count_q, count_d;

    // Next-state slot contents: pops shift slot 1 forward, writes fill the first free slot.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        count_d = count_q;
        case (buf_op(pop, wr_en))
            BUF_POP: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            BUF_WR: begin
                if (count_q == 2'd0) buf0_d = wr_data;
                else                 buf1_d = wr_data;
                count_d = count_q + 2'd1;
            end
            BUF_POP_WR: begin
                // Head leaves and the new word takes the tail; count holds.
                if (count_q == BUF_FULL) begin
                    buf0_d = buf1_q;
                    buf1_d = wr_data;
                end else begin
                    buf0_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q  <= '0;
            buf1_q  <= '0;
            count_q <= '0;
        end else begin
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            count_q <= count_d;
        end
    end

    // A write into a full buffer with no pop would lose a word.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(wr_en && !pop && count_q == BUF_FULL));
    end

    assign head  = buf0_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a fifo with one-cycle read latency into a valid/ready stream.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [1:0]             occupancy
);

    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                   pop;
    logic                   arrive;
    logic                   rd_en;
    logic [2:0]             pending;
    occ_t                   count;

    assign pop    = valid_out & ready_in;
    // Data for a read issued last cycle lands now; drop it while in reset.
    assign arrive = inflight_q & ~rst;

    // Issue a read only if a slot is certain to be free when its data arrives.
    always_comb begin
        pending      = 3'(count) + 3'(inflight_q) - 3'(pop);
        rd_en        = ~rst & ~fifo_empty & (pending <= 3'(READER_BUF_DEPTH - 1));
        inflight_d   = rd_en;
        word_count_d = word_count_q + COUNT_WIDTH'(pop);
    end

    // In-flight flag and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (arrive),
        .wr_data (fifo_data),
        .pop     (pop),
        .head    (data_out),
        .count   (count)
    );

    assign fifo_rd_en = rd_en;
    assign valid_out  = (count != 2'd0);
    assign occupancy  = count;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural fifo on the read side, scoreboard on the output.
module tb_fifo_reader;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic [CW-1:0] word_count;
    logic [1:0]    occupancy;

    fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .word_count (word_count),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mq[$];     // fifo contents
    logic [DW-1:0] exp_q[$];  // scoreboard
    logic [CW-1:0] exp_wc = '0;
    int cyc = 0;
    int underflow = 0;
    int n_chk = 0, n_fail = 0;

    // stats gathered by the monitor
    int n_rd, first_rd, last_rd, n_pop, first_pop, last_pop, e_cyc, v_cyc;
    logic prev_stall = 1'b0, prev_empty = 1'b1, prev_valid = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // fifo model: registered empty flag, one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                if (mq.size() != 0) fifo_data <= mq.pop_front();
                else                underflow <= underflow + 1;
            end
            fifo_empty <= (mq.size() == 0);
        end
    end

    // monitor: sample away from the active edge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("word_count", word_count, exp_wc);
            chk("occ_max", 64'(occupancy <= 2'd2), 1);
            if (prev_stall) chk("hold", data_out, prev_data);
            if (fifo_rd_en) begin
                if (n_rd == 0) first_rd = cyc;
                last_rd = cyc;
                n_rd++;
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else                   chk("data", data_out, exp_q.pop_front());
                exp_wc++;
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            if (e_cyc < 0 && prev_empty && !fifo_empty) e_cyc = cyc;
            if (v_cyc < 0 && !prev_valid && valid_out) v_cyc = cyc;
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
        end
        prev_empty = fifo_empty;
        prev_valid = valid_out;
    end

    task automatic push(input logic [DW-1:0] d);
        mq.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic clr_stats();
        n_rd = 0; n_pop = 0; first_rd = 0; last_rd = 0;
        first_pop = 0; last_pop = 0; e_cyc = -1; v_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        exp_wc = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || occupancy != 2'd0) && k < bound) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(k < bound), 1);
    endtask

    initial begin
        clr_stats();
        repeat (3) tick();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_occ", occupancy, 0);
        rst = 1'b0;

        // four words, downstream always ready
        clr_stats();
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) push(DW'(16'hA0 + i));
        wait_drain(50);
        chk("first_latency", 64'(v_cyc - e_cyc), 2);
        chk("p1_pops", n_pop, 4);
        chk("p1_span", 64'(last_pop - first_pop), 3);
        chk("p1_wc", word_count, 4);

        // 64-word stream, read enable continuous
        do_reset(1);
        clr_stats();
        for (int i = 0; i < 64; i++) push(DW'(16'h1000 + i));
        wait_drain(200);
        chk("p2_reads", n_rd, 64);
        chk("p2_rd_span", 64'(last_rd - first_rd), 63);
        chk("p2_pops", n_pop, 64);
        chk("p2_pop_span", 64'(last_pop - first_pop), 63);

        // downstream stall for 10 cycles
        do_reset(1);
        for (int i = 0; i < 30; i++) push(DW'(16'h2000 + i));
        repeat (5) tick();
        ready_in = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("stall_occ", occupancy, 2);
        chk("stall_rd_en", fifo_rd_en, 0);
        chk("stall_valid", valid_out, 1);
        tick();
        ready_in = 1'b1;
        wait_drain(100);

        // random backpressure over 200 words
        do_reset(1);
        for (int i = 0; i < 200; i++) push(DW'(16'h3000 + i));
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
            ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        ready_in = 1'b1;
        wait_drain(100);

        // reset with a full buffer and a read in flight
        do_reset(1);
        ready_in = 1'b0;
        for (int i = 0; i < 8; i++) push(DW'(16'h4000 + i));
        for (int k = 0; k < 20 && occupancy != 2'd2; k++) tick();
        chk("p5_full", occupancy, 2);
        ready_in = 1'b1;
        @(negedge clk);
        chk("p5_rd_issued", fifo_rd_en, 1);
        tick();
        ready_in = 1'b0;
        do_reset(1);
        chk("p5_rd_en", fifo_rd_en, 0);
        chk("p5_data", data_out, 0);
        chk("p5_valid", valid_out, 0);
        chk("p5_wc", word_count, 0);
        chk("p5_occ", occupancy, 0);
        repeat (3) tick();
        chk("p5_no_stale", valid_out, 0);
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) push(DW'(16'h5000 + i));
        wait_drain(50);

        // counter wrap with a 4-bit counter
        do_reset(1);
        for (int i = 0; i < 17; i++) push(DW'(16'h6000 + i));
        wait_drain(100);
        chk("wc_wrap", word_count, 1);

        chk("fifo_underflow", underflow, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
